// File: rtl/lenet_pkg.sv
// Shared definitions for the LeNet-5 inference top.
// Holds the class-score geometry, the result-frame constants, the reader
// state enum, the class index type and the frame byte selector used by the
// result serializer.
package lenet_pkg;

   localparam int         NUM_CLASSES = 10;
   localparam int         SCORE_W     = 32;
   localparam logic [7:0] HDR_BYTE    = 8'hAA;
   localparam int         FRAME_BYTES = 6;

   typedef logic [3:0] class_idx_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_READ,
      ST_CMP,
      ST_TX,
      ST_DONE
   } reader_state_t;

   // Frame layout: header, class index, then the score big-endian.
   function automatic logic [7:0] frame_byte(input logic [2:0]  sel,
                                             input logic [7:0]  hdr,
                                             input class_idx_t  cls,
                                             input logic [31:0] score);
      logic [7:0] b;
      case (sel)
         3'd0:    b = hdr;
         3'd1:    b = {4'b0000, cls};
         3'd2:    b = score[31:24];
         3'd3:    b = score[23:16];
         3'd4:    b = score[15:8];
         default: b = score[7:0];
      endcase
      return b;
   endfunction

endpackage

// File: rtl/class_score_reader_tx.sv
// Result frame serializer.
// On a load strobe it presents the 6-byte result frame one byte at a time
// on a valid/ready byte stream and reports the acceptance of the last byte.
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   load            one-cycle strobe: start a new frame (pred/max stable)
//   pred_class      argmax index placed in byte 1
//   max_score       score placed big-endian in bytes 2..5
//   tx_ready        downstream accepts the byte when tx_valid && tx_ready
//   tx_data         current frame byte
//   tx_valid        frame byte valid
//   frame_done      high in the cycle whose edge accepts the last byte
module result_frame_tx
   import lenet_pkg::*;
#(
   parameter logic [7:0] HDR_BYTE = lenet_pkg::HDR_BYTE,
   parameter int         SCORE_W  = lenet_pkg::SCORE_W
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      load,
   input  class_idx_t                pred_class,
   input  logic signed [SCORE_W-1:0] max_score,
   input  logic                      tx_ready,
   output logic [7:0]                tx_data,
   output logic                      tx_valid,
   output logic                      frame_done
);

   logic [2:0] byte_cnt;
   logic       accept;

   assign accept     = tx_valid && tx_ready;
   assign frame_done = accept && (byte_cnt == 3'(FRAME_BYTES - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         byte_cnt <= 3'd0;
         tx_valid <= 1'b0;
         tx_data  <= 8'd0;
      end else if (load) begin
         byte_cnt <= 3'd0;
         tx_valid <= 1'b1;
         tx_data  <= frame_byte(3'd0, HDR_BYTE, pred_class, max_score);
      end else if (accept) begin
         if (frame_done) begin
            tx_valid <= 1'b0;
         end else begin
            // Next byte follows immediately so a held-high ready streams.
            byte_cnt <= byte_cnt + 3'd1;
            tx_data  <= frame_byte(byte_cnt + 3'd1, HDR_BYTE, pred_class, max_score);
         end
      end
   end

endmodule

// File: rtl/class_score_reader.sv
// Class score reader: scans the FC3 score RAM, finds the argmax and sends
// the 6-byte result frame toward the UART TX path.
// Ports:
//   clk, rst         clock and synchronous active-high reset
//   start            one-cycle request, sampled only in IDLE
//   busy             high from start acceptance until the done pulse ends
//   done             one-cycle pulse after the last frame byte is accepted
//   score_addr       score RAM read address
//   score_rd_data    signed score, valid RD_LAT cycles after the address
//   pred_class       argmax index, held until the next scan ends
//   max_score        score at pred_class, held likewise
//   tx_data/tx_valid/tx_ready   byte stream toward the host link
module class_score_reader
   import lenet_pkg::*;
#(
   parameter int         NUM_CLASSES = lenet_pkg::NUM_CLASSES,
   parameter int         SCORE_W     = lenet_pkg::SCORE_W,
   parameter int         RD_LAT      = 1,
   parameter logic [7:0] HDR_BYTE    = lenet_pkg::HDR_BYTE
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start,
   output logic                      busy,
   output logic                      done,
   output class_idx_t                score_addr,
   input  logic signed [SCORE_W-1:0] score_rd_data,
   output class_idx_t                pred_class,
   output logic signed [SCORE_W-1:0] max_score,
   output logic [7:0]                tx_data,
   output logic                      tx_valid,
   input  logic                      tx_ready
);

   reader_state_t             state;
   class_idx_t                idx;
   class_idx_t                run_idx;
   logic signed [SCORE_W-1:0] run_max;
   logic [1:0]                wait_cnt;
   logic                      load;
   logic                      frame_done;
   logic                      take;

   // Strictly greater keeps the lowest index on ties; the first class
   // always seeds the running max.
   assign take = (idx == 4'd0) || (score_rd_data > run_max);

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_IDLE;
         idx        <= 4'd0;
         run_idx    <= 4'd0;
         run_max    <= '0;
         wait_cnt   <= 2'd0;
         load       <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         score_addr <= 4'd0;
         pred_class <= 4'd0;
         max_score  <= '0;
      end else begin
         done <= 1'b0;
         load <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  idx        <= 4'd0;
                  score_addr <= 4'd0;
                  wait_cnt   <= 2'd0;
                  busy       <= 1'b1;
                  state      <= ST_READ;
               end
            end
            ST_READ: begin
               // Occupies RD_LAT cycles so the RAM data lands in CMP.
               if (wait_cnt == 2'(RD_LAT - 1)) begin
                  wait_cnt <= 2'd0;
                  state    <= ST_CMP;
               end else begin
                  wait_cnt <= wait_cnt + 2'd1;
               end
            end
            ST_CMP: begin
               if (take) begin
                  run_max <= score_rd_data;
                  run_idx <= idx;
               end
               if (idx == 4'(NUM_CLASSES - 1)) begin
                  pred_class <= take ? idx : run_idx;
                  max_score  <= take ? score_rd_data : run_max;
                  load       <= 1'b1;
                  state      <= ST_TX;
               end else begin
                  idx        <= idx + 4'd1;
                  score_addr <= idx + 4'd1;
                  state      <= ST_READ;
               end
            end
            ST_TX: begin
               if (frame_done) begin
                  done  <= 1'b1;
                  state <= ST_DONE;
               end
            end
            ST_DONE: begin
               busy  <= 1'b0;
               state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   result_frame_tx #(
      .HDR_BYTE (HDR_BYTE),
      .SCORE_W  (SCORE_W)
   ) u_tx (
      .clk        (clk),
      .rst        (rst),
      .load       (load),
      .pred_class (pred_class),
      .max_score  (max_score),
      .tx_ready   (tx_ready),
      .tx_data    (tx_data),
      .tx_valid   (tx_valid),
      .frame_done (frame_done)
   );

endmodule

// File: tb/tb_class_score_reader.sv
module tb_class_score_reader;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst, start, tx_ready, sel;
   logic start0, start3;
   assign start0 = start & ~sel;
   assign start3 = start & sel;

   logic              busy0, done0, valid0, busy3, done3, valid3;
   logic [3:0]        addr0, pred0, addr3, pred3;
   logic signed [31:0] rd0, max0, rd3, max3;
   logic [7:0]        data0, data3;

   logic signed [31:0] mem [16];
   logic [3:0] a0;
   logic [3:0] a3 [3];

   // Score RAM models: latency 1 for the default build, 3 for the second.
   always @(posedge clk) begin
      a0    <= addr0;
      a3[0] <= addr3;
      a3[1] <= a3[0];
      a3[2] <= a3[1];
   end
   assign rd0 = mem[a0];
   assign rd3 = mem[a3[2]];

   class_score_reader u_dut (
      .clk(clk), .rst(rst), .start(start0), .busy(busy0), .done(done0),
      .score_addr(addr0), .score_rd_data(rd0), .pred_class(pred0),
      .max_score(max0), .tx_data(data0), .tx_valid(valid0), .tx_ready(tx_ready)
   );

   class_score_reader #(.RD_LAT(3)) u_dut3 (
      .clk(clk), .rst(rst), .start(start3), .busy(busy3), .done(done3),
      .score_addr(addr3), .score_rd_data(rd3), .pred_class(pred3),
      .max_score(max3), .tx_data(data3), .tx_valid(valid3), .tx_ready(tx_ready)
   );

   logic              o_busy, o_done, o_valid;
   logic [3:0]        o_pred;
   logic signed [31:0] o_max;
   logic [7:0]        o_data;
   assign o_busy  = sel ? busy3  : busy0;
   assign o_done  = sel ? done3  : done0;
   assign o_valid = sel ? valid3 : valid0;
   assign o_pred  = sel ? pred3  : pred0;
   assign o_max   = sel ? max3   : max0;
   assign o_data  = sel ? data3  : data0;

   int checks = 0;
   int failures = 0;

   // Reference model results
   logic [7:0]         exp_frame [6];
   int                 exp_cls;
   logic signed [31:0] exp_max;

   // Observations of one run
   logic [7:0] got_q [$];
   int first_valid_k, done_k, done_cnt, stall_err, post_valid;
   bit timed_out, busy_k0;

   task automatic model();
      int best = 0;
      for (int i = 1; i < 10; i++)
         if (mem[i] > mem[best]) best = i;
      exp_cls      = best;
      exp_max      = mem[best];
      exp_frame[0] = 8'hAA;
      exp_frame[1] = 8'(best);
      exp_frame[2] = exp_max[31:24];
      exp_frame[3] = exp_max[23:16];
      exp_frame[4] = exp_max[15:8];
      exp_frame[5] = exp_max[7:0];
   endtask

   task automatic load_mem(input int v0, input int v1, input int v2, input int v3,
                           input int v4, input int v5, input int v6, input int v7,
                           input int v8, input int v9);
      mem[0] = v0; mem[1] = v1; mem[2] = v2; mem[3] = v3; mem[4] = v4;
      mem[5] = v5; mem[6] = v6; mem[7] = v7; mem[8] = v8; mem[9] = v9;
      for (int i = 10; i < 16; i++) mem[i] = 32'sd0;
   endtask

   // Starts a scan on the selected instance and records the frame.
   // k counts edges after the accepting edge E0; a sample taken at a
   // negedge shows the state produced by edge E0+k.
   task automatic run_frame(input int mode, input int extra_k);
      int k = 0;
      int low_left = 0;
      bit held = 0;
      bit prev_v = 0, prev_r = 0;
      logic [7:0] prev_d = 8'd0;
      got_q.delete();
      first_valid_k = -1; done_k = -1; done_cnt = 0; stall_err = 0;
      post_valid = 0; timed_out = 0; busy_k0 = 0;
      @(negedge clk);
      start = 1'b1;
      tx_ready = (mode == 0);
      @(posedge clk);
      #1 start = 1'b0;
      while (1) begin
         @(negedge clk);
         start = (k == extra_k);
         if (k == 0) busy_k0 = o_busy;
         if (o_valid && first_valid_k < 0) first_valid_k = k;
         if (done_k >= 0 && o_valid) post_valid++;
         if (o_done) begin
            done_cnt++;
            if (done_k < 0) done_k = k;
         end
         if (prev_v && !prev_r && o_valid && o_data !== prev_d) stall_err++;
         if (mode == 1) begin
            if (low_left > 0) begin
               tx_ready = 1'b0;
               low_left--;
            end else if (!held && got_q.size() == 3) begin
               held = 1; low_left = 49; tx_ready = 1'b0;
            end else begin
               tx_ready = 1'($urandom_range(0, 1));
            end
         end
         if (o_valid && tx_ready) got_q.push_back(o_data);
         prev_v = o_valid; prev_r = tx_ready; prev_d = o_data;
         k++;
         if (done_k >= 0 && k > done_k + 60) break;
         if (k > 3000) begin
            timed_out = 1;
            break;
         end
      end
      start = 1'b0;
      tx_ready = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++; if (busy0 !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy0); end
      checks++; if (done0 !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done0); end
      checks++; if (addr0 !== 4'd0) begin failures++; $display("FAIL reset_addr got=%0d exp=0", addr0); end
      checks++; if (pred0 !== 4'd0) begin failures++; $display("FAIL reset_pred got=%0d exp=0", pred0); end
      checks++; if (max0 !== 32'sd0) begin failures++; $display("FAIL reset_max got=%0d exp=0", max0); end
      checks++; if (data0 !== 8'd0) begin failures++; $display("FAIL reset_txdata got=%h exp=00", data0); end
      checks++; if (valid0 !== 1'b0 || valid3 !== 1'b0) begin failures++; $display("FAIL reset_txvalid got=%b%b exp=00", valid0, valid3); end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_basic();
      sel = 0;
      load_mem(5, -3, 100, 7, 0, 99, -1, 2, 3, 4);
      model();
      run_frame(0, -1);
      checks++; if (timed_out) begin failures++; $display("FAIL basic_timeout got=timeout exp=done"); end
      checks++; if (busy_k0 !== 1'b1) begin failures++; $display("FAIL basic_busy_start got=%b exp=1", busy_k0); end
      checks++; if (first_valid_k != 21) begin failures++; $display("FAIL basic_first_valid got=E0+%0d exp=E0+21", first_valid_k); end
      checks++; if (done_k != 27) begin failures++; $display("FAIL basic_done_time got=E0+%0d exp=E0+27", done_k); end
      checks++; if (done_cnt != 1) begin failures++; $display("FAIL basic_done_count got=%0d exp=1", done_cnt); end
      checks++; if (got_q.size() != 6) begin failures++; $display("FAIL basic_len got=%0d exp=6", got_q.size()); end
      for (int i = 0; i < 6 && i < got_q.size(); i++) begin
         checks++; if (got_q[i] !== exp_frame[i]) begin failures++; $display("FAIL basic_byte%0d got=%h exp=%h", i, got_q[i], exp_frame[i]); end
      end
      checks++; if (o_pred !== 4'd2 || exp_cls != 2) begin failures++; $display("FAIL basic_pred got=%0d exp=2", o_pred); end
      checks++; if (o_max !== 32'sd100) begin failures++; $display("FAIL basic_max got=%0d exp=100", o_max); end
      checks++; if (o_busy !== 1'b0) begin failures++; $display("FAIL basic_busy_after got=%b exp=0", o_busy); end
   endtask

   task automatic test_tie();
      sel = 0;
      load_mem(0, 0, 0, 50, 0, 0, 0, 0, 50, 0);
      model();
      run_frame(0, -1);
      checks++; if (got_q.size() != 6 || timed_out) begin failures++; $display("FAIL tie_len got=%0d exp=6", got_q.size()); end
      for (int i = 0; i < 6 && i < got_q.size(); i++) begin
         checks++; if (got_q[i] !== exp_frame[i]) begin failures++; $display("FAIL tie_byte%0d got=%h exp=%h", i, got_q[i], exp_frame[i]); end
      end
      checks++; if (o_pred !== 4'd3) begin failures++; $display("FAIL tie_pred got=%0d exp=3", o_pred); end
   endtask

   task automatic test_extremes();
      sel = 0;
      load_mem(32'h80000000, 32'h80000000, 32'h80000000, 32'h80000000, 32'h80000000,
               32'h80000000, 32'h80000000, 32'h80000000, 32'h80000000, 32'h80000001);
      model();
      run_frame(0, -1);
      checks++; if (got_q.size() != 6 || timed_out) begin failures++; $display("FAIL neg_len got=%0d exp=6", got_q.size()); end
      for (int i = 0; i < 6 && i < got_q.size(); i++) begin
         checks++; if (got_q[i] !== exp_frame[i]) begin failures++; $display("FAIL neg_byte%0d got=%h exp=%h", i, got_q[i], exp_frame[i]); end
      end
      checks++; if (o_pred !== 4'd9) begin failures++; $display("FAIL neg_pred got=%0d exp=9", o_pred); end
      load_mem(-7, -7, -7, -7, -7, -7, -7, -7, -7, -7);
      model();
      run_frame(0, -1);
      checks++; if (o_pred !== 4'd0) begin failures++; $display("FAIL equal_pred got=%0d exp=0", o_pred); end
      checks++; if (o_max !== -32'sd7) begin failures++; $display("FAIL equal_max got=%0d exp=-7", o_max); end
   endtask

   task automatic test_stall_random();
      sel = 0;
      for (int it = 0; it < 3; it++) begin
         for (int i = 0; i < 10; i++) mem[i] = $signed($urandom);
         if (it == 1) mem[7] = mem[2];
         model();
         run_frame(1, -1);
         checks++; if (timed_out) begin failures++; $display("FAIL stall_timeout it=%0d got=timeout exp=done", it); end
         checks++; if (stall_err != 0) begin failures++; $display("FAIL stall_stable it=%0d got=%0d changes exp=0", it, stall_err); end
         checks++; if (done_cnt != 1) begin failures++; $display("FAIL stall_done_count it=%0d got=%0d exp=1", it, done_cnt); end
         checks++; if (got_q.size() != 6) begin failures++; $display("FAIL stall_len it=%0d got=%0d exp=6", it, got_q.size()); end
         for (int i = 0; i < 6 && i < got_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_frame[i]) begin failures++; $display("FAIL stall_byte%0d it=%0d got=%h exp=%h", i, it, got_q[i], exp_frame[i]); end
         end
         checks++; if (o_pred !== 4'(exp_cls) || o_max !== exp_max) begin failures++; $display("FAIL stall_result it=%0d got=%0d/%0d exp=%0d/%0d", it, o_pred, o_max, exp_cls, exp_max); end
      end
   endtask

   task automatic test_rd_lat3();
      sel = 1;
      load_mem(5, -3, 100, 7, 0, 99, -1, 2, 3, 4);
      model();
      run_frame(0, 10);  // start pulsed again mid-scan
      checks++; if (first_valid_k != 41) begin failures++; $display("FAIL lat3_first_valid got=E0+%0d exp=E0+41", first_valid_k); end
      checks++; if (got_q.size() != 6 || timed_out) begin failures++; $display("FAIL lat3_len got=%0d exp=6", got_q.size()); end
      for (int i = 0; i < 6 && i < got_q.size(); i++) begin
         checks++; if (got_q[i] !== exp_frame[i]) begin failures++; $display("FAIL lat3_byte%0d got=%h exp=%h", i, got_q[i], exp_frame[i]); end
      end
      checks++; if (done_cnt != 1 || post_valid != 0) begin failures++; $display("FAIL lat3_ignored_start got=done%0d/valid%0d exp=1/0", done_cnt, post_valid); end
      sel = 0;
   endtask

   task automatic test_reset_mid_tx();
      int k = 0;
      int acc = 0;
      int extra_done = 0;
      sel = 0;
      load_mem(5, -3, 100, 7, 0, 99, -1, 2, 3, 4);
      model();
      tx_ready = 1'b1;
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      while (k < 200) begin
         @(negedge clk);
         if (o_valid && acc == 3) break;
         if (o_valid) acc++;
         k++;
      end
      checks++; if (k >= 200) begin failures++; $display("FAIL rstmid_reach got=timeout exp=byte3"); end
      checks++; if (o_data !== exp_frame[3]) begin failures++; $display("FAIL rstmid_byte3 got=%h exp=%h", o_data, exp_frame[3]); end
      tx_ready = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      checks++; if (o_valid !== 1'b0 || o_busy !== 1'b0 || o_done !== 1'b0) begin failures++; $display("FAIL rstmid_abort got=v%b b%b d%b exp=000", o_valid, o_busy, o_done); end
      rst = 1'b0;
      tx_ready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (o_done || o_valid) extra_done++;
      end
      checks++; if (extra_done != 0) begin failures++; $display("FAIL rstmid_quiet got=%0d exp=0", extra_done); end
      run_frame(0, -1);
      checks++; if (got_q.size() != 6 || done_cnt != 1 || timed_out) begin failures++; $display("FAIL rstmid_restart got=%0d bytes/%0d done exp=6/1", got_q.size(), done_cnt); end
      for (int i = 0; i < 6 && i < got_q.size(); i++) begin
         checks++; if (got_q[i] !== exp_frame[i]) begin failures++; $display("FAIL rstmid_byte%0d got=%h exp=%h", i, got_q[i], exp_frame[i]); end
      end
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; tx_ready = 1'b0; sel = 1'b0;
      for (int i = 0; i < 16; i++) mem[i] = 32'sd0;
      test_reset();
      test_basic();
      test_tie();
      test_extremes();
      test_stall_random();
      test_rd_lat3();
      test_reset_mid_tx();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
